// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
// Linear frequency-sweep generator. It produces the phase-increment word for
// an NCO. The word steps from f_start toward f_stop by f_step and holds each
// value for dwell+1 enabled cycles. It supports one-shot and repeating sweeps.
// While a sweep runs, all inputs are ignored except abort.
module nco_sweep_ctrl #(
  parameter int APR = 32,
  parameter int DW  = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           start,
  input  logic           abort,
  input  logic           mode,
  input  logic [APR-1:0] f_start,
  input  logic [APR-1:0] f_stop,
  input  logic [APR-1:0] f_step,
  input  logic [DW-1:0]  dwell,
  output logic [APR-1:0] phi_inc_o,
  output logic           busy,
  output logic           done,
  output logic           wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  stateT          r_state;
  stateT          w_stateNxt;

  logic [APR-1:0] r_phiInc;
  logic [APR-1:0] w_phiIncNxt;
  logic [DW-1:0]  r_dwellCnt;
  logic [DW-1:0]  w_dwellCntNxt;
  logic           r_busy;
  logic           w_busyNxt;
  logic           r_done;
  logic           w_doneNxt;
  logic           r_wrap;
  logic           w_wrapNxt;
  logic           w_latch;

  // Parameters captured when a sweep starts.
  logic [APR-1:0] r_startL;
  logic [APR-1:0] r_stopL;
  logic [APR-1:0] r_stepL;
  logic [DW-1:0]  r_dwellL;
  logic           r_modeL;

  // The sum is one bit wider than APR so that a carry out of the top bit
  // counts as passing the stop value, instead of silently wrapping.
  logic [APR:0]   w_sum;
  logic           w_atEnd;

  // Next-state and next-value logic for the sweep.
  always_comb begin
    w_stateNxt    = r_state;
    w_phiIncNxt   = r_phiInc;
    w_dwellCntNxt = r_dwellCnt;
    w_busyNxt     = r_busy;
    w_doneNxt     = 1'b0;
    w_wrapNxt     = 1'b0;
    w_latch       = 1'b0;
    w_sum         = {1'b0, r_phiInc} + {1'b0, r_stepL};
    w_atEnd       = w_sum[APR] | (w_sum > {1'b0, r_stopL});

    case (r_state)
      IDLE: begin
        if (start) begin
          w_latch       = 1'b1;
          w_phiIncNxt   = f_start;
          w_dwellCntNxt = '0;
          w_busyNxt     = 1'b1;
          w_stateNxt    = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_busyNxt  = 1'b0;
          w_stateNxt = IDLE;
        end else if (r_dwellCnt != r_dwellL) begin
          w_dwellCntNxt = r_dwellCnt + {{(DW-1){1'b0}}, 1'b1};
        end else begin
          w_dwellCntNxt = '0;
          if (!w_atEnd) begin
            w_phiIncNxt = w_sum[APR-1:0];
          end else if (!r_modeL) begin
            w_phiIncNxt = r_stopL;
            w_doneNxt   = 1'b1;
            w_busyNxt   = 1'b0;
            w_stateNxt  = IDLE;
          end else begin
            w_phiIncNxt = r_startL;
            w_wrapNxt   = 1'b1;
          end
        end
      end
      default: begin
        w_stateNxt = IDLE;
        w_busyNxt  = 1'b0;
      end
    endcase
  end

  // State and sweep registers. They advance only on enabled cycles. The
  // done and wrap pulses last one clk and drop on the next edge even when
  // clken is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_phiInc   <= '0;
      r_dwellCnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
    end else if (clken) begin
      r_state    <= w_stateNxt;
      r_phiInc   <= w_phiIncNxt;
      r_dwellCnt <= w_dwellCntNxt;
      r_busy     <= w_busyNxt;
      r_done     <= w_doneNxt;
      r_wrap     <= w_wrapNxt;
    end else begin
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
    end
  end

  // Capture the sweep parameters when a sweep begins from IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_startL <= '0;
      r_stopL  <= '0;
      r_stepL  <= '0;
      r_dwellL <= '0;
      r_modeL  <= 1'b0;
    end else if (clken && w_latch) begin
      r_startL <= f_start;
      r_stopL  <= f_stop;
      r_stepL  <= f_step;
      r_dwellL <= dwell;
      r_modeL  <= mode;
    end
  end

  assign phi_inc_o = r_phiInc;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wrap      = r_wrap;

endmodule
